// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU sharing arbiter and its neighbours.
//   alu_op_t    : 3-bit ALU opcode (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR)
//   arb_state_t : arbiter FSM state (IDLE, EXEC, RESP)
//   DATA_W      : operand / result width
//   OP_W        : opcode width
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    // Prefixed because and/or/xor/not are reserved words.
    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_NOT = 3'd5,
        ALU_SHL = 3'd6,
        ALU_SHR = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter_if
// Request / response bundle between the two requesters and the arbiter.
//   master : requester side (drives req_*, receives req_ready and resp_*)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if import alu_pkg::*; ();

    logic [1:0]        req_valid;
    logic [DATA_W-1:0] req_a0;
    logic [DATA_W-1:0] req_b0;
    logic [DATA_W-1:0] req_a1;
    logic [DATA_W-1:0] req_b1;
    alu_op_t           req_op0;
    alu_op_t           req_op1;
    logic [1:0]        req_ready;
    logic [1:0]        resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_carry;
    logic              resp_zero;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        input  req_ready, resp_valid, resp_data, resp_carry, resp_zero
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1,
        output req_ready, resp_valid, resp_data, resp_carry, resp_zero
    );

endinterface

// File: rtl/mux2by1_8bit.sv
// ---------------------------------------------------------------------------
// mux2by1_8bit
// 8-bit two-input multiplexer used for ALU operand steering.
//   sel in 1 : 0 selects d0, 1 selects d1
//   d0  in 8 : input 0
//   d1  in 8 : input 1
//   y   out 8: selected data
// ---------------------------------------------------------------------------
module mux2by1_8bit import alu_pkg::*; (
    input  logic              sel,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic [DATA_W-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            assign y[gi] = sel ? d1[gi] : d0[gi];
        end
    endgenerate

endmodule

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational.
//   req   in  2 : request vector
//   last  in  1 : port that won most recently
//   grant out 2 : one-hot grant, or zero when nothing is requested
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // Under contention the port that did not win last time goes first.
        if (req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational 8-bit ALU between two requesters. A round-robin
// winner is accepted in IDLE, its operands/opcode are registered into the ALU
// input registers, the ALU result and flags are captured in EXEC, and a
// one-cycle resp_valid pulse is returned to the winner in RESP.
//   clk, reset  : clock, synchronous active-high reset
//   bus         : request/response bundle (slave side)
//   alu_a/b/op  : registered ALU operands and opcode
//   alu_result, alu_carry, alu_zero : combinational ALU outputs
//   busy        : high while in EXEC or RESP
// ---------------------------------------------------------------------------
module alu_share_arbiter import alu_pkg::*; (
    input  logic                clk,
    input  logic                reset,
    alu_share_arbiter_if.slave  bus,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output alu_op_t             alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_carry,
    input  logic                alu_zero,
    output logic                busy
);

    arb_state_t        state_reg;
    logic              owner_reg;
    logic              last_reg;
    logic [DATA_W-1:0] alu_a_reg;
    logic [DATA_W-1:0] alu_b_reg;
    alu_op_t           alu_op_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic              resp_carry_reg;
    logic              resp_zero_reg;
    logic [1:0]        resp_valid_reg;

    logic [1:0]        grant;
    logic              winner;
    logic              accept;
    logic [DATA_W-1:0] alu_a_next;
    logic [DATA_W-1:0] alu_b_next;
    alu_op_t           alu_op_next;

    rr_arb2 u_arb (
        .req   (bus.req_valid),
        .last  (last_reg),
        .grant (grant)
    );

    // grant is one-hot or zero, so bit 1 alone identifies the winner.
    assign winner = grant[1];

    // Ready is suppressed while reset is high so nothing is offered that the
    // reset branch would then drop.
    assign accept = (state_reg == IDLE) && !reset && (grant != 2'b00);

    mux2by1_8bit u_mux_a (
        .sel (winner),
        .d0  (bus.req_a0),
        .d1  (bus.req_a1),
        .y   (alu_a_next)
    );

    mux2by1_8bit u_mux_b (
        .sel (winner),
        .d0  (bus.req_b0),
        .d1  (bus.req_b1),
        .y   (alu_b_next)
    );

    assign alu_op_next = winner ? bus.req_op1 : bus.req_op0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_reg       <= 1'b1;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_op_reg     <= ALU_ADD;
            resp_data_reg  <= '0;
            resp_carry_reg <= 1'b0;
            resp_zero_reg  <= 1'b0;
            resp_valid_reg <= 2'b00;
        end else begin
            resp_valid_reg <= 2'b00;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        alu_a_reg  <= alu_a_next;
                        alu_b_reg  <= alu_b_next;
                        alu_op_reg <= alu_op_next;
                        owner_reg  <= winner;
                        last_reg   <= winner;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data_reg  <= alu_result;
                    resp_carry_reg <= alu_carry;
                    resp_zero_reg  <= alu_zero;
                    // Pulse is registered here so it is high for exactly RESP.
                    resp_valid_reg <= owner_reg ? 2'b10 : 2'b01;
                    state_reg      <= RESP;
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = accept ? grant : 2'b00;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_data  = resp_data_reg;
    assign bus.resp_carry = resp_carry_reg;
    assign bus.resp_zero  = resp_zero_reg;
    assign alu_a          = alu_a_reg;
    assign alu_b          = alu_b_reg;
    assign alu_op         = alu_op_reg;
    assign busy           = (state_reg != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational 8-bit ALU between two requesters (port 0, port 1). Performs round-robin arbitration, registers the winner's operands and opcode into the ALU input registers, captures result and flags, and returns them to the winner with a one-cycle response pulse. Sits directly in front of the ALU core, one level above the operand steering muxes.

## Interface
- No parameters; data width fixed at 8, opcode width fixed at 3.
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- req_valid  in  2  per-port request valid
- req_a0, req_b0  in  8 each  port 0 operands
- req_a1, req_b1  in  8 each  port 1 operands
- req_op0, req_op1  in  3 each  port opcodes (alu_op_t)
- req_ready  out  2  per-port accept; at most one bit set
- alu_a, alu_b  out  8 each  registered ALU operands
- alu_op  out  3  registered ALU opcode
- alu_result  in  8  ALU result, combinational from alu_a/alu_b/alu_op
- alu_carry, alu_zero  in  1 each  ALU flags
- resp_valid  out  2  one-cycle response pulse to the served port
- resp_data  out  8  captured result, shared by both ports
- resp_carry, resp_zero  out  1 each  captured flags
- busy  out  1  high in EXEC and RESP

## Operation
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE:
  - winner computed from req_valid and rr pointer `last` (1 bit, reset value 1).
  - Only one valid: that port wins. Both valid: port != last wins. None valid: stay IDLE, req_ready = 0.
  - req_ready[winner] = 1 combinationally.
  - On the edge: alu_a/alu_b/alu_op ← winner's fields, owner ← winner, last ← winner, → EXEC.
- EXEC: req_ready = 0. On the edge: resp_data/carry/zero ← alu_result/alu_carry/alu_zero, → RESP.
- RESP: resp_valid[owner] = 1 for exactly this cycle. Next edge → IDLE.
- Handshake: a request is consumed only at an edge where req_valid[i] & req_ready[i]. Requesters hold valid and fields stable until accepted. Deasserting valid before acceptance is legal and withdraws the request.
- alu_a/alu_b/alu_op and resp_* hold their values until overwritten. They are not cleared on return to IDLE.
- Arithmetic is performed entirely by the ALU. This block never alters data widths or values.
- Reset mid-operation (EXEC or RESP): next state IDLE, pending response discarded, no resp_valid pulse.
- Reset values: req_ready = 0, resp_valid = 0, busy = 0, alu_a = alu_b = 0, alu_op = 0 (ADD), resp_data = 0, resp_carry = resp_zero = 0, owner = 0, last = 1.

## Timing
- Accept at edge N (IDLE, req_ready high), EXEC in cycle N+1, resp_valid high in cycle N+2, IDLE again in cycle N+3.
- Latency from accept edge to resp_valid: 2 cycles.
- Throughput: one operation per 3 cycles. Sustained contention alternates 0,1,0,1…
- req_ready and resp_valid are never both high in the same cycle.
- req_ready is combinational from req_valid in IDLE only. All other outputs are registered or decoded from state.

## Structure
- Shared package alu_pkg holds:
  - typedef enum logic [2:0] alu_op_t: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR.
  - typedef enum logic [1:0] arb_state_t: IDLE, EXEC, RESP.
  - Constants DATA_W = 8 and OP_W = 3.
- Sub-module rr_arb2:
  - Inputs: req[1:0], last. Output: grant[1:0] (one-hot or zero).
  - Purely combinational; instantiated once.
- Operand steering into the ALU registers uses two mux2by1_8bit instances, one for A and one for B, with sel = winner. Opcode selection uses a 3-bit inline mux.

## Test plan
- Reset, then idle 5 cycles → all outputs 0, busy = 0, no req_ready.
- Port 0 only: a = 0x7F, b = 0x01, op = ADD; ALU model gives 0x80, carry 0 → req_ready = 2'b01 at accept; resp_valid = 2'b01 two cycles later; resp_data = 0x80, zero = 0.
- Both valid from reset: port 0 SUB 0x05,0x05 and port 1 AND 0xF0,0x0F → port 0 served first (resp_data 0x00, zero 1), then port 1 (0x00, zero 1). resp_valid pulses 2'b01 then 2'b10, 3 cycles apart.
- Sustained contention over 6 operations → grant order 0,1,0,1,0,1; no port starved; each resp_valid exactly 1 cycle wide.
- Port 1 ADD 0xFF,0x01 → resp_data 0x00, carry 1, zero 1. Port 1 raises valid again during EXEC → not accepted until the following IDLE.
- Reset asserted in EXEC → next cycle IDLE, resp_valid never pulses. A fresh port 0 request afterwards wins, since last = 1.
